layer_out_sequencer: RTL and testbench

//   Sequencer between two neuron layers. Collects one frame of NUM_NEURON parallel neuron outputs.

---
 rtl/layer_out_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_layer_out_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_out_sequencer.sv
// layer_out_sequencer: gathers one frame of NUM_NEURON parallel neuron outputs,
// each arriving on its own one-cycle valid pulse, then replays the frame as a
// serial valid/ready stream (index 0..NUM_NEURON-1) for the next dense layer.
// Optional feature macro: LAYER_OUT_SEQ_DBUF_EN adds a shadow bank/mask so the
// next frame can be collected while the current one is streaming out.
module layer_out_sequencer #(
   parameter int unsigned NUM_NEURON = 10,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                             i_clk,
   input  logic                             i_reset,
   input  logic [NUM_NEURON*DATA_WIDTH-1:0] i_data,
   input  logic [NUM_NEURON-1:0]            i_data_valid,
   output logic [DATA_WIDTH-1:0]            o_data,
   output logic                             o_data_valid,
   input  logic                             i_data_ready,
   output logic                             o_busy,
   output logic                             o_frame_done,
   output logic [CNT_WIDTH-1:0]             o_frame_cnt,
   output logic                             o_err_overrun
);

   localparam int unsigned      IDX_W    = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURON - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SEND = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]            state;
   logic [1:0]            state_nxt;

   logic [DATA_WIDTH-1:0] in_word [NUM_NEURON];
   logic [DATA_WIDTH-1:0] bank    [NUM_NEURON];
   logic [NUM_NEURON-1:0] mask;
   logic [NUM_NEURON-1:0] mask_merge;
   logic [IDX_W-1:0]      idx;
   logic [IDX_W-1:0]      idx_inc;
   logic                  frame_full;
   logic                  xfer;
   logic                  last_word;
   logic                  overrun_hit;
   logic [DATA_WIDTH-1:0] first_word;

`ifdef LAYER_OUT_SEQ_DBUF_EN
   logic [DATA_WIDTH-1:0] sh_bank [NUM_NEURON];
   logic [NUM_NEURON-1:0] sh_mask;
   logic [NUM_NEURON-1:0] sh_merge;
   logic                  sh_full;
   logic [DATA_WIDTH-1:0] sh_first;
`endif

   // Split the flat upstream bus into per-neuron words.
   always_comb begin
      for (int k = 0; k < NUM_NEURON; k++) begin
         in_word[k] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Frame-completion, handshake and overrun qualifiers.
   always_comb begin
      mask_merge = mask | i_data_valid;
      frame_full = &mask_merge;
      // Word 0 may land on the very edge that completes the frame, so bypass it.
      first_word = i_data_valid[0] ? in_word[0] : bank[0];
      xfer       = o_data_valid & i_data_ready;
      last_word  = (idx == LAST_IDX);
      idx_inc    = idx + IDX_W'(1);
`ifdef LAYER_OUT_SEQ_DBUF_EN
      sh_merge    = sh_mask | i_data_valid;
      sh_full     = &sh_merge;
      sh_first    = i_data_valid[0] ? in_word[0] : sh_bank[0];
      overrun_hit = |(i_data_valid & sh_mask);
`else
      overrun_hit = |i_data_valid;
`endif
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (frame_full) begin
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (xfer && last_word) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
`ifdef LAYER_OUT_SEQ_DBUF_EN
            state_nxt = sh_full ? SEND : IDLE;
`else
            state_nxt = IDLE;
`endif
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Active bank and mask: filled while collecting, reloaded from the shadow after DONE.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         for (int k = 0; k < NUM_NEURON; k++) begin
            bank[k] <= '0;
         end
         mask <= '0;
      end else begin
         case (state)
            IDLE: begin
               for (int k = 0; k < NUM_NEURON; k++) begin
                  if (i_data_valid[k]) begin
                     bank[k] <= in_word[k];
                  end
               end
               mask <= mask_merge;
            end
            SEND: begin
               if (xfer && last_word) begin
                  mask <= '0;
               end
            end
`ifdef LAYER_OUT_SEQ_DBUF_EN
            DONE: begin
               for (int k = 0; k < NUM_NEURON; k++) begin
                  bank[k] <= i_data_valid[k] ? in_word[k] : sh_bank[k];
               end
               mask <= sh_merge;
            end
`endif
            default: begin
            end
         endcase
      end
   end

`ifdef LAYER_OUT_SEQ_DBUF_EN
   // Shadow bank: catches the next frame while the current one streams out.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         for (int k = 0; k < NUM_NEURON; k++) begin
            sh_bank[k] <= '0;
         end
         sh_mask <= '0;
      end else begin
         case (state)
            SEND: begin
               for (int k = 0; k < NUM_NEURON; k++) begin
                  if (i_data_valid[k]) begin
                     sh_bank[k] <= in_word[k];
                  end
               end
               sh_mask <= sh_merge;
            end
            DONE: begin
               for (int k = 0; k < NUM_NEURON; k++) begin
                  sh_bank[k] <= '0;
               end
               sh_mask <= '0;
            end
            default: begin
            end
         endcase
      end
   end
`endif

   // Serial output stream, status flags and frame counter.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         idx           <= '0;
         o_data        <= '0;
         o_data_valid  <= 1'b0;
         o_busy        <= 1'b0;
         o_frame_done  <= 1'b0;
         o_frame_cnt   <= '0;
         o_err_overrun <= 1'b0;
      end else begin
         o_busy       <= (state_nxt != IDLE);
         o_frame_done <= (state_nxt == DONE);
         case (state)
            IDLE: begin
               if (frame_full) begin
                  idx          <= '0;
                  o_data       <= first_word;
                  o_data_valid <= 1'b1;
               end
            end
            SEND: begin
               if (xfer) begin
                  if (last_word) begin
                     idx          <= '0;
                     o_data_valid <= 1'b0;
                  end else begin
                     idx    <= idx_inc;
                     o_data <= bank[idx_inc];
                  end
               end
               if (overrun_hit) begin
                  o_err_overrun <= 1'b1;
               end
            end
            DONE: begin
               o_frame_cnt <= o_frame_cnt + CNT_WIDTH'(1);
               if (overrun_hit) begin
                  o_err_overrun <= 1'b1;
               end
`ifdef LAYER_OUT_SEQ_DBUF_EN
               if (sh_full) begin
                  idx          <= '0;
                  o_data       <= sh_first;
                  o_data_valid <= 1'b1;
               end
`endif
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_layer_out_sequencer.sv
// Bench for layer_out_sequencer: directed frames checked every cycle against a
// frame-level model (collect array -> word queue), plus literal spot checks.
module tb_layer_out_sequencer;

   localparam int unsigned N  = 10;
   localparam int unsigned DW = 16;
   localparam int unsigned CW = 2;

   logic              i_clk;
   logic              i_reset;
   logic [N*DW-1:0]   i_data;
   logic [N-1:0]      i_data_valid;
   logic [DW-1:0]     o_data;
   logic              o_data_valid;
   logic              i_data_ready;
   logic              o_busy;
   logic              o_frame_done;
   logic [CW-1:0]     o_frame_cnt;
   logic              o_err_overrun;

   layer_out_sequencer #(.NUM_NEURON(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_data        (i_data),
      .i_data_valid  (i_data_valid),
      .o_data        (o_data),
      .o_data_valid  (o_data_valid),
      .i_data_ready  (i_data_ready),
      .o_busy        (o_busy),
      .o_frame_done  (o_frame_done),
      .o_frame_cnt   (o_frame_cnt),
      .o_err_overrun (o_err_overrun)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- frame-level model ----------------
   logic [DW-1:0] col_w [N];
   logic [N-1:0]  col_m;
   logic [DW-1:0] m_q [$];
   logic          m_busy, m_valid, m_done, m_err;
   logic [CW-1:0] m_cnt;
`ifdef LAYER_OUT_SEQ_DBUF_EN
   logic [DW-1:0] sh_w [N];
   logic [N-1:0]  sh_m;
`endif

   function automatic logic [DW-1:0] in_word(input int k);
      return i_data[k*DW +: DW];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) col_w[k] = '0;
      col_m = '0;
      m_q.delete();
      m_busy = 1'b0; m_valid = 1'b0; m_done = 1'b0; m_err = 1'b0; m_cnt = '0;
`ifdef LAYER_OUT_SEQ_DBUF_EN
      sh_m = '0;
`endif
   endtask

   // A full frame becomes a queue of words in index order.
   task automatic model_launch();
      m_q.delete();
      for (int k = 0; k < N; k++) m_q.push_back(col_w[k]);
      col_m   = '0;
      m_busy  = 1'b1;
      m_valid = 1'b1;
   endtask

   // Applies the inputs seen this cycle to get the outputs after the next edge.
   task automatic model_step();
      logic [N-1:0] pv;
      pv = i_data_valid;
      if (!m_busy) begin
         for (int k = 0; k < N; k++)
            if (pv[k]) begin col_w[k] = in_word(k); col_m[k] = 1'b1; end
         if (&col_m) model_launch();
      end else if (m_done) begin
         m_done = 1'b0;
         m_busy = 1'b0;
         m_cnt  = m_cnt + 2'd1;
`ifdef LAYER_OUT_SEQ_DBUF_EN
         for (int k = 0; k < N; k++)
            if (pv[k]) begin
               if (sh_m[k]) m_err = 1'b1;
               sh_w[k] = in_word(k); sh_m[k] = 1'b1;
            end
         for (int k = 0; k < N; k++) col_w[k] = sh_w[k];
         col_m = sh_m;
         sh_m  = '0;
         if (&col_m) model_launch();
`else
         if (|pv) m_err = 1'b1;
`endif
      end else begin
`ifdef LAYER_OUT_SEQ_DBUF_EN
         for (int k = 0; k < N; k++)
            if (pv[k]) begin
               if (sh_m[k]) m_err = 1'b1;
               sh_w[k] = in_word(k); sh_m[k] = 1'b1;
            end
`else
         if (|pv) m_err = 1'b1;
`endif
         if (i_data_ready) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin m_valid = 1'b0; m_done = 1'b1; end
         end
      end
   endtask

   // Compare process: every cycle, mid-period.
   always @(negedge i_clk) begin
      if (!i_reset) model_reset();
      chk("mon_busy",    32'(o_busy),        32'(m_busy));
      chk("mon_valid",   32'(o_data_valid),  32'(m_valid));
      if (m_valid) chk("mon_data", 32'(o_data), 32'(m_q[0]));
      chk("mon_done",    32'(o_frame_done),  32'(m_done));
      chk("mon_cnt",     32'(o_frame_cnt),   32'(m_cnt));
      chk("mon_overrun", 32'(o_err_overrun), 32'(m_err));
      if (i_reset) model_step();
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic [N-1:0] m, input int base);
      i_data_valid = m;
      for (int k = 0; k < N; k++) i_data[k*DW +: DW] = DW'(base + k);
   endtask

   task automatic pulse(input logic [N-1:0] m, input int base);
      @(posedge i_clk); #1 drive(m, base);
      @(posedge i_clk); #1 i_data_valid = '0;
   endtask

   task automatic do_reset();
      @(posedge i_clk); #1 i_reset = 1'b0;
      @(posedge i_clk); #1 i_reset = 1'b1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_data"},    32'(o_data),        32'd0);
      chk({tag, "_valid"},   32'(o_data_valid),  32'd0);
      chk({tag, "_busy"},    32'(o_busy),        32'd0);
      chk({tag, "_done"},    32'(o_frame_done),  32'd0);
      chk({tag, "_cnt"},     32'(o_frame_cnt),   32'd0);
      chk({tag, "_overrun"}, 32'(o_err_overrun), 32'd0);
   endtask

   // Waits (bounded) for the done pulse, then one more cycle for the counter.
   task automatic wait_done(input string tag);
      int c = 0;
      do begin @(negedge i_clk); c++; end while (!o_frame_done && c < 100);
      chk({tag, "_done_seen"}, 32'(o_frame_done), 32'd1);
      @(negedge i_clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int            order [N] = '{9, 3, 0, 1, 2, 4, 5, 6, 7, 8};
   logic [N-1:0]  one_hot;
   logic [CW-1:0] cnt_seq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

   initial begin
      i_reset = 1'b0; i_data = '0; i_data_valid = '0; i_data_ready = 1'b1;
      repeat (2) @(negedge i_clk);
      check_all_zero("reset");
      @(posedge i_clk); #1 i_reset = 1'b1;

      $display("T1 basic frame");
      do_reset();
      pulse('1, 32'h0100);
      for (int i = 0; i < N; i++) begin
         @(negedge i_clk);
         chk("t1_valid", 32'(o_data_valid), 32'd1);
         chk("t1_data",  32'(o_data), 32'h0100 + 32'(i));
      end
      @(negedge i_clk);
      chk("t1_done",     32'(o_frame_done), 32'd1);
      chk("t1_cnt_pre",  32'(o_frame_cnt),  32'd0);
      @(negedge i_clk);
      chk("t1_done_end", 32'(o_frame_done), 32'd0);
      chk("t1_cnt",      32'(o_frame_cnt),  32'd1);
      chk("t1_busy",     32'(o_busy),       32'd0);

      $display("T2 scattered arrival");
      do_reset();
      for (int j = 0; j < N; j++) begin
         one_hot = '0;
         one_hot[order[j]] = 1'b1;
         @(posedge i_clk); #1 drive(one_hot, 32'h0200);
      end
      @(posedge i_clk); #1 i_data_valid = '0;
      for (int i = 0; i < N; i++) begin
         @(negedge i_clk);
         chk("t2_valid", 32'(o_data_valid), 32'd1);
         chk("t2_data",  32'(o_data), 32'h0200 + 32'(i));
      end
      wait_done("t2");
      chk("t2_cnt", 32'(o_frame_cnt), 32'd1);

      $display("T3 backpressure");
      do_reset();
      pulse('1, 32'h0300);
      repeat (4) @(posedge i_clk);
      #1 i_data_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge i_clk);
         chk("t3_hold_valid", 32'(o_data_valid), 32'd1);
         chk("t3_hold_data",  32'(o_data), 32'h0304);
         @(posedge i_clk);
      end
      #1 i_data_ready = 1'b1;
      @(negedge i_clk);
      chk("t3_resume_data", 32'(o_data), 32'h0304);
      @(negedge i_clk);
      chk("t3_next_data",   32'(o_data), 32'h0305);
      wait_done("t3");
      chk("t3_cnt", 32'(o_frame_cnt), 32'd1);

`ifndef LAYER_OUT_SEQ_DBUF_EN
      $display("T4 overrun");
      do_reset();
      pulse('1, 32'h0400);
      repeat (2) @(posedge i_clk);
      #1 drive(10'b00_0000_0100, 32'h0dea);
      @(posedge i_clk); #1 i_data_valid = '0;
      @(negedge i_clk);
      chk("t4_overrun_set", 32'(o_err_overrun), 32'd1);
      wait_done("t4");
      chk("t4_overrun_sticky", 32'(o_err_overrun), 32'd1);
      repeat (3) @(negedge i_clk);
      chk("t4_idle_busy", 32'(o_busy), 32'd0);
      pulse(10'b11_1111_1011, 32'h0410);
      @(negedge i_clk);
      chk("t4_nine_valid", 32'(o_data_valid), 32'd0);
      chk("t4_nine_busy",  32'(o_busy),       32'd0);
      pulse(10'b00_0000_0100, 32'h0410);
      @(negedge i_clk);
      chk("t4_refill_valid", 32'(o_data_valid), 32'd1);
      chk("t4_refill_data",  32'(o_data),       32'h0410);
      wait_done("t4b");
      chk("t4_cnt",        32'(o_frame_cnt),   32'd2);
      chk("t4_overrun_end", 32'(o_err_overrun), 32'd1);
`else
      $display("T6 double buffer");
      do_reset();
      pulse('1, 32'h0700);
      for (int i = 0; i < 2*N + 1; i++) begin
         @(negedge i_clk);
         if (i < N) begin
            chk("t6_valid_a", 32'(o_data_valid), 32'd1);
            chk("t6_data_a",  32'(o_data), 32'h0700 + 32'(i));
         end else if (i == N) begin
            chk("t6_gap_valid", 32'(o_data_valid), 32'd0);
            chk("t6_gap_done",  32'(o_frame_done), 32'd1);
         end else begin
            chk("t6_valid_b", 32'(o_data_valid), 32'd1);
            chk("t6_data_b",  32'(o_data), 32'h0800 + 32'(i - N - 1));
         end
         if (i == 2) begin @(posedge i_clk); #1 drive('1, 32'h0800); end
         if (i == 3) begin @(posedge i_clk); #1 i_data_valid = '0; end
      end
      wait_done("t6");
      chk("t6_cnt",     32'(o_frame_cnt),   32'd2);
      chk("t6_overrun", 32'(o_err_overrun), 32'd0);
`endif

      $display("T5 reset mid-send");
      do_reset();
      pulse('1, 32'h0500);
      repeat (5) @(posedge i_clk);
      #1 chk("t5_before_data", 32'(o_data), 32'h0505);
      i_reset = 1'b0;
      #1 check_all_zero("t5_rst");
      @(posedge i_clk); #1 i_reset = 1'b1;
      pulse('1, 32'h0600);
      @(negedge i_clk);
      chk("t5_fresh_data", 32'(o_data), 32'h0600);
      wait_done("t5");
      chk("t5_cnt", 32'(o_frame_cnt), 32'd1);

      $display("T7 counter wrap");
      do_reset();
      for (int f = 0; f < 4; f++) begin
         pulse('1, 32'h0900 + 16 * f);
         wait_done("t7");
         chk("t7_cnt", 32'(o_frame_cnt), 32'(cnt_seq[f]));
      end

      repeat (2) @(negedge i_clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
